wb_addr_decoder: RTL
====================

// Module: wb_addr_decoder
// PURPOSE
//  Parametrised Wishbone B4 classic interconnect: one CPU master port fanned out to NSLV slave ports.
//  Slave regions are configured by BASE/MASK parameter vectors. Decode is registered and the selected
//  slave is locked for the whole transfer. Unmapped addresses and stalled slaves end in an error response.
//  Sits between the core's data bus and memory/UART/timer; replaces the fixed-map crossbar.
// PARAMETERS
//  NSLV        4                     number of slave ports (1..16)
//  AW          32                    address width
//  DW          32                    data width
//  SLV_BASE    {NSLV{AW'h0}}         packed base address per slave, slave i at [i*AW +: AW]
//  SLV_MASK    {NSLV{AW'h0}}         packed compare mask per slave: hit_i = ((ADR & MASK_i) == BASE_i)
//  TIMEOUT     255                   max cycles in ACTIVE without slave ACK before error (>=1)
//  LEGACY_ERR  0                     1: unmapped/timeout answered with ACK + DAT_I=0 instead of ERR
// PORTS
//  clk         in   1         system clock
//  rst         in   1         synchronous reset, active low
//  m_adr       in   AW        master address
//  m_dat_w     in   DW        master write data
//  m_we        in   1         master write enable
//  m_cyc       in   1         master cycle
//  m_stb       in   1         master strobe
//  m_dat_r     out  DW        read data to master
//  m_ack       out  1         acknowledge to master
//  m_err       out  1         bus error to master
//  s_adr       out  AW        address broadcast to all slaves
//  s_dat_w     out  DW        write data broadcast to all slaves
//  s_we        out  1         write enable broadcast
//  s_cyc       out  NSLV      per-slave cycle, only the selected slave's bit is set
//  s_stb       out  NSLV      per-slave strobe, only the selected slave's bit is set
//  s_dat_r     in   NSLV*DW   per-slave read data, slave i at [i*DW +: DW]
//  s_ack       in   NSLV      per-slave acknowledge
//  err_adr     out  AW        address of the most recent failed transfer
//  err_valid   out  1         sticky error flag; cleared by reset only
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): state=IDLE, sel=0, tcnt=0, err_adr=0, err_valid=0.
//   All of s_cyc, s_stb, m_ack and m_err are 0; m_dat_r is 0.
//  s_adr, s_dat_w and s_we are combinational copies of the master signals in every state.
//  Decode: hit vector is computed combinationally. On overlapping regions the lowest index wins.
//  FSM:
//   IDLE:   if m_cyc&m_stb: any hit -> sel<=index, tcnt<=0, ACTIVE; no hit -> err_adr<=m_adr, ERROR.
//           No slave strobed and no m_ack in IDLE. Decode adds exactly 1 cycle of latency.
//   ACTIVE: s_cyc[sel]=m_cyc, s_stb[sel]=m_stb, m_dat_r=s_dat_r[sel], m_ack=s_ack[sel] (combinational).
//           s_ack[sel]=1 -> IDLE (next transfer decodes again).
//           m_cyc=0 (abort) -> IDLE immediately, no error.
//           tcnt==TIMEOUT-1 and no ack -> err_adr<=m_adr, ERROR; s_stb/s_cyc drop in ERROR.
//           tcnt increments every ACTIVE cycle and saturates; it never wraps.
//           s_ack of non-selected slaves is ignored.
//   ERROR:  one cycle. m_err=1 (LEGACY_ERR=0) or m_ack=1 with m_dat_r=0 (LEGACY_ERR=1).
//           err_valid<=1. Always -> IDLE.
//  Ack and error are one-cycle responses; the master must deassert STB or present a new request after them.
//  Simultaneous s_ack and timeout on the same cycle: ack wins, no error.
//  rst=0 mid-transfer returns to IDLE on that edge. Outputs drop with no ack or error.
// TESTING
//  1 Map s0 0x0/0xFFF00000, s1 0x00100000/0xFFFFFFF0. Read 0x00000040 with s0 acking 1 cycle
//    after its strobe, data 0xDEADBEEF -> s_stb=0b01 from cycle 2, m_ack with m_dat_r=0xDEADBEEF, s1 never strobed.
//  2 Write 0x00100000 data 0x41 -> s_stb[1] only, s_dat_w=0x41, s_we=1, m_ack when s1 acks.
//  3 Access 0x00200000 (unmapped), LEGACY_ERR=0 -> m_err=1 for 1 cycle, err_adr=0x00200000,
//    err_valid=1. Repeat with LEGACY_ERR=1 -> m_ack=1, m_dat_r=0.
//  4 TIMEOUT=8, slave never acks -> m_err on the 10th cycle after the request, s_stb dropped, FSM in IDLE.
//  5 Slave acks on the same cycle as the timeout -> m_ack only. Separately, drop m_cyc mid-ACTIVE ->
//    IDLE with no err/ack.
//  6 Assert rst=0 during ACTIVE -> all outputs 0 next edge. err_valid=0. The next transfer decodes normally.

Source files
------------

// File: rtl/wb_addr_decoder.sv
// wb_addr_decoder
//   Wishbone B4 classic interconnect. One master port is fanned out to NSLV
//   slave ports. Each slave owns the region where (adr & MASK_i) == BASE_i.
//   The request is decoded in IDLE, and the chosen slave stays locked until
//   it acks, the master drops CYC, or the transfer times out.
//   Unmapped addresses and timeouts finish with a one-cycle error response.
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for CYC&STB, decode the address on request
//   ST_ACTIVE | selected slave strobed, waiting for its ACK
//   ST_ERROR  | one-cycle error response (ERR, or ACK with zero data in legacy mode)
//
// Ports
//   clk, rst          system clock, synchronous active-low reset
//   m_*               master side: address, write data, we, cyc, stb in;
//                     read data, ack, err out
//   s_adr/s_dat_w/s_we broadcast copies of the master signals
//   s_cyc/s_stb       one-hot per-slave cycle/strobe (selected slave only)
//   s_dat_r/s_ack     per-slave read data (slave i at [i*DW +: DW]) and ack
//   err_adr           address of the most recent failed transfer
//   err_valid         sticky error flag, cleared by reset only
module wb_addr_decoder #(
    parameter int                   NSLV       = 4,
    parameter int                   AW         = 32,
    parameter int                   DW         = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE   = '0,
    parameter logic [NSLV*AW-1:0]   SLV_MASK   = '0,
    parameter int                   TIMEOUT    = 255,
    parameter bit                   LEGACY_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        m_adr,
    input  logic [DW-1:0]        m_dat_w,
    input  logic                 m_we,
    input  logic                 m_cyc,
    input  logic                 m_stb,
    output logic [DW-1:0]        m_dat_r,
    output logic                 m_ack,
    output logic                 m_err,
    output logic [AW-1:0]        s_adr,
    output logic [DW-1:0]        s_dat_w,
    output logic                 s_we,
    output logic [NSLV-1:0]      s_cyc,
    output logic [NSLV-1:0]      s_stb,
    input  logic [NSLV*DW-1:0]   s_dat_r,
    input  logic [NSLV-1:0]      s_ack,
    output logic [AW-1:0]        err_adr,
    output logic                 err_valid
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [AW-1:0]   err_adr_q, err_adr_d;
    logic            err_valid_q, err_valid_d;

    logic            hit_any;
    logic [SW-1:0]   hit_idx;
    logic            req;
    logic            ack_sel;
    logic            tc_hit;

    // Scan from the top index down so that the lowest matching slave is the
    // last assignment and therefore wins on overlapping regions.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit_any = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign req     = m_cyc & m_stb;
    assign ack_sel = s_ack[sel_q];
    assign tc_hit  = (tcnt_q == TC_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            tcnt_q      <= '0;
            err_adr_q   <= '0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            tcnt_q      <= tcnt_d;
            err_adr_q   <= err_adr_d;
            err_valid_q <= err_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        tcnt_d      = tcnt_q;
        err_adr_d   = err_adr_q;
        err_valid_d = err_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit_any) begin
                        sel_d   = hit_idx;
                        tcnt_d  = '0;
                        state_d = ST_ACTIVE;
                    end else begin
                        err_adr_d = m_adr;
                        state_d   = ST_ERROR;
                    end
                end
            end
            ST_ACTIVE: begin
                // Saturate rather than wrap so a held count can never alias
                // back below the terminal value.
                if (!tc_hit) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                // Ack beats abort and timeout; abort beats timeout.
                if (ack_sel) begin
                    state_d = ST_IDLE;
                end else if (!m_cyc) begin
                    state_d = ST_IDLE;
                end else if (tc_hit) begin
                    err_adr_d = m_adr;
                    state_d   = ST_ERROR;
                end
            end
            ST_ERROR: begin
                err_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_cyc   = '0;
        s_stb   = '0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_dat_r = '0;
        case (state_q)
            ST_ACTIVE: begin
                s_cyc[sel_q] = m_cyc;
                s_stb[sel_q] = m_stb;
                m_dat_r      = s_dat_r[sel_q*DW +: DW];
                m_ack        = s_ack[sel_q];
            end
            ST_ERROR: begin
                if (LEGACY_ERR) begin
                    m_ack = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign s_adr     = m_adr;
    assign s_dat_w   = m_dat_w;
    assign s_we      = m_we;
    assign err_adr   = err_adr_q;
    assign err_valid = err_valid_q;

endmodule
